// File: rtl/err_pkg.sv
// Shared types and helpers for the PID error front end.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
//
// Contents:
//   sm32_t        - 32-bit sign-magnitude value (bit 31 sign, 30:0 magnitude)
//   fe_state_t    - front-end FSM states
//   SM_MAX_MAG    - largest representable magnitude
//   SM_ZERO       - canonical zero (+0)
//   sm_to_s33     - sign-magnitude to 33-bit two's complement
//   s34_to_sm_sat - 34-bit two's complement to saturated sign-magnitude
package err_pkg;

  typedef struct packed {
    logic        sign;
    logic [30:0] mag;
  } sm32_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILT  = 3'd1,
    ST_SUB   = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4
  } fe_state_t;

  localparam logic [30:0] SM_MAX_MAG = 31'h7FFFFFFF;
  localparam sm32_t       SM_ZERO    = '{sign: 1'b0, mag: 31'd0};

  // -0 (sign set, zero magnitude) maps to 0 like any other zero.
  function automatic logic signed [32:0] sm_to_s33(input sm32_t v);
    logic signed [32:0] m;
    m = $signed({2'b00, v.mag});
    return v.sign ? -m : m;
  endfunction

  // Clamp to +/-(2^31-1) and convert; the result never carries a negative zero.
  function automatic sm32_t s34_to_sm_sat(input logic signed [33:0] d);
    sm32_t              r;
    logic signed [33:0] maxv;
    logic        [33:0] absd;
    maxv = $signed({3'b000, SM_MAX_MAG});
    r    = SM_ZERO;
    absd = '0;
    if (d > maxv) begin
      r = '{sign: 1'b0, mag: SM_MAX_MAG};
    end else if (d < -maxv) begin
      r = '{sign: 1'b1, mag: SM_MAX_MAG};
    end else begin
      absd   = d[33] ? 34'(-d) : 34'(d);
      r.mag  = absd[30:0];
      r.sign = d[33] && (absd[30:0] != 31'd0);
    end
    return r;
  endfunction

endpackage

// File: rtl/err_frontend_mov_avg.sv
// Moving-average filter: 2^AVG_LOG2-deep window of signed samples plus running sum.
// Latency: one cycle; sum/avg reflect a sample on the cycle after its upd strobe.
// Backpressure: none; every qualified strobe is absorbed.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (window and sum clear)
//   en        - global enable; state holds when low
//   upd       - single-cycle strobe: push din, drop the oldest sample
//   din       - signed 33-bit sample
//   avg       - sum >>> AVG_LOG2 (arithmetic), from the registered sum
module mov_avg #(
  parameter int AVG_LOG2 = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               upd,
  input  logic signed [32:0] din,
  output logic signed [32:0] avg
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 33 + AVG_LOG2;

  // win[0] is the newest sample, win[DEPTH-1] the one leaving next.
  logic signed [32:0]   win [DEPTH];
  logic signed [SW-1:0] sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        win[i] <= '0;
      end
    end else if (en && upd) begin
      // Sum grows by AVG_LOG2 bits so a window full of extremes cannot wrap.
      sum    <= sum + SW'(din) - SW'(win[DEPTH-1]);
      win[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        win[i] <= win[i-1];
      end
    end
  end

  // The mean of 33-bit samples always fits back into 33 bits.
  assign avg = 33'(sum >>> AVG_LOG2);

endmodule

// File: rtl/err_frontend.sv
// PID front end: filter PV samples, form saturated setpoint error, start a PID frame.
// Latency: pv_valid in cycle N -> error registered end of N+2 -> start_calc in N+3.
// Backpressure: one frame in flight; pv_valid outside IDLE is dropped and counted.
//
// Optional build macro: ERR_DEADBAND_EN (force |error| < DEADBAND to +0).
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   en           - global enable; all state (counters included) holds when low
//   setpoint     - sign-magnitude target, sampled only in SUB
//   pv, pv_valid - sign-magnitude sample and its single-cycle strobe
//   pid_done     - PID frame-complete pulse, honoured only in WAIT
//   error        - registered sign-magnitude error, stable from ISSUE until IDLE
//   start_calc   - one-cycle frame start pulse
//   delta_t      - cycles since the previous start_calc (valid with start_calc)
//   busy         - FSM not in IDLE
//   overrun_cnt  - saturating count of dropped samples
//   timeout      - sticky: a frame was abandoned waiting for pid_done
module err_frontend
  import err_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1024,
  parameter int DEADBAND = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] setpoint,
  input  logic [31:0] pv,
  input  logic        pv_valid,
  input  logic        pid_done,
  output logic [31:0] error,
  output logic        start_calc,
  output logic [31:0] delta_t,
  output logic        busy,
  output logic [7:0]  overrun_cnt,
  output logic        timeout
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

`ifdef ERR_DEADBAND_EN
  localparam bit DB_ON = 1'b1;
`else
  localparam bit DB_ON = 1'b0;
`endif

  fe_state_t          state;
  sm32_t              pv_q;
  logic [31:0]        cyc_cnt;
  logic [31:0]        cyc_inc;
  logic [WW-1:0]      wait_cnt;
  logic signed [32:0] pv_s33;
  logic signed [32:0] avg;
  logic signed [33:0] diff;
  sm32_t              diff_sm;
  sm32_t              err_next;
  logic               avg_upd;

  assign pv_s33  = sm_to_s33(pv_q);
  assign avg_upd = (state == ST_FILT);

  mov_avg #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_mov_avg (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .upd (avg_upd),
    .din (pv_s33),
    .avg (avg)
  );

  // Both operands are within +/-(2^31-1), so 34 bits cannot overflow.
  assign diff    = 34'(sm_to_s33(setpoint)) - 34'(avg);
  assign diff_sm = s34_to_sm_sat(diff);

  always_comb begin
    err_next = diff_sm;
    if (DB_ON && (32'(diff_sm.mag) < 32'(DEADBAND))) begin
      err_next = SM_ZERO;
    end
  end

  assign cyc_inc = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pv_q        <= SM_ZERO;
      error       <= '0;
      start_calc  <= 1'b0;
      delta_t     <= '0;
      overrun_cnt <= '0;
      timeout     <= 1'b0;
      cyc_cnt     <= '0;
      wait_cnt    <= '0;
    end else if (en) begin
      start_calc <= 1'b0;
      cyc_cnt    <= cyc_inc;

      if (pv_valid && (state != ST_IDLE) && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end

      case (state)
        ST_IDLE: begin
          if (pv_valid) begin
            pv_q  <= pv;
            state <= ST_FILT;
          end
        end
        ST_FILT: begin
          state <= ST_SUB;
        end
        ST_SUB: begin
          error      <= err_next;
          start_calc <= 1'b1;
          // delta_t is the counter value during the ISSUE cycle, so it is
          // presented alongside start_calc.
          delta_t    <= cyc_inc;
          state      <= ST_ISSUE;
        end
        ST_ISSUE: begin
          // pid_done here is deliberately ignored; only WAIT listens for it.
          cyc_cnt  <= 32'd1;
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (pid_done) begin
            state <= ST_IDLE;
          end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_err_frontend.sv
// Directed bench for err_frontend with a reference moving-average/error model.
// Expected errors are queued at stimulus time and popped at each start_calc.
module tb_err_frontend;

  localparam int AVG_LOG2 = 2;
  localparam int DEPTH    = 1 << AVG_LOG2;
  localparam int TIMEOUT  = 1024;
  localparam int DEADBAND = 16;
  localparam longint MAXM = 64'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [31:0] setpoint = '0;
  logic [31:0] pv = '0;
  logic        pv_valid = 1'b0;
  logic        pid_done = 1'b0;
  logic [31:0] error;
  logic        start_calc;
  logic [31:0] delta_t;
  logic        busy;
  logic [7:0]  overrun_cnt;
  logic        timeout;

  err_frontend #(
    .AVG_LOG2 (AVG_LOG2),
    .TIMEOUT  (TIMEOUT),
    .DEADBAND (DEADBAND)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .setpoint    (setpoint),
    .pv          (pv),
    .pv_valid    (pv_valid),
    .pid_done    (pid_done),
    .error       (error),
    .start_calc  (start_calc),
    .delta_t     (delta_t),
    .busy        (busy),
    .overrun_cnt (overrun_cnt),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int          total  = 0;
  int          passed = 0;
  logic [31:0] exp_q[$];
  longint      mwin[DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  function automatic longint sm2l(input logic [31:0] v);
    longint m;
    m = longint'(v[30:0]);
    return v[31] ? -m : m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mwin[i] = 0;
  endtask

  function automatic logic [31:0] model_sample(input logic [31:0] v, input logic [31:0] sp);
    longint sum, avg, d, mag;
    logic   s;
    for (int i = DEPTH - 1; i > 0; i--) mwin[i] = mwin[i-1];
    mwin[0] = sm2l(v);
    sum = 0;
    for (int i = 0; i < DEPTH; i++) sum += mwin[i];
    avg = sum >>> AVG_LOG2;
    d   = sm2l(sp) - avg;
    if (d > MAXM) d = MAXM;
    else if (d < -MAXM) d = -MAXM;
    s   = (d < 0);
    mag = s ? -d : d;
`ifdef ERR_DEADBAND_EN
    if (mag < DEADBAND) mag = 0;
`endif
    if (mag == 0) s = 1'b0;
    return {s, mag[30:0]};
  endfunction

  // Drive one sample from IDLE; returns one time unit after the ISSUE edge.
  task automatic send(input logic [31:0] v, input logic [31:0] sp,
                      input logic chk_dt, input logic [31:0] exp_dt);
    int lat;
    setpoint = sp;
    pv       = v;
    pv_valid = 1'b1;
    exp_q.push_back(model_sample(v, sp));
    @(posedge clk); #1;
    pv_valid = 1'b0;
    lat = 1;
    while (!start_calc && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("start_latency", lat, 3);
    if (exp_q.size() > 0) check("error", error, exp_q.pop_front());
    if (chk_dt) check("delta_t", delta_t, exp_dt);
  endtask

  task automatic done_after(input int n);
    repeat (n) @(posedge clk);
    #1;
    pid_done = 1'b1;
    @(posedge clk); #1;
    pid_done = 1'b0;
    check("idle_after_done", busy, 0);
  endtask

  task automatic frame(input logic [31:0] v, input logic [31:0] sp);
    send(v, sp, 1'b0, '0);
    done_after(2);
  endtask

  initial begin
    int          n;
    logic [31:0] saved_err;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_error", error, 0);
    check("rst_start_calc", start_calc, 0);
    check("rst_delta_t", delta_t, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun_cnt, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;

    // delta_t from reset release, then 20 cycles between samples; the same
    // four samples of +400 against +1000 form the ramp 900/800/700/600.
    repeat (10) @(posedge clk);
    #1;
    send(32'h0000_0190, 32'h0000_03E8, 1'b1, 32'd13);
    check("ramp_0", error, 32'h0000_0384);
    done_after(5);
    repeat (11) @(posedge clk);
    #1;
    send(32'h0000_0190, 32'h0000_03E8, 1'b1, 32'd20);
    check("ramp_1", error, 32'h0000_0320);
    done_after(5);

    send(32'h0000_0190, 32'h0000_03E8, 1'b0, '0);
    pid_done = 1'b1;
    @(posedge clk); #1;
    pid_done = 1'b0;
    check("done_in_issue_ignored", busy, 1);
    check("start_single_cycle", start_calc, 0);
    done_after(3);

    send(32'h0000_0190, 32'h0000_03E8, 1'b0, '0);
    check("ramp_3", error, 32'h0000_0258);
    done_after(2);

    // Saturation toward the negative limit, then zero results.
    for (int i = 0; i < DEPTH; i++) frame(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    check("sat_neg", error, 32'hFFFF_FFFF);
    frame(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    check("zero_pos", error, 32'h0000_0000);
    for (int i = 0; i < DEPTH; i++) frame(32'h8000_0005, 32'h8000_0005);
    check("zero_no_neg_zero", error, 32'h0000_0000);

    // Reset while in SUB aborts the frame.
    setpoint = 32'h0000_03E8;
    pv       = 32'h0000_0190;
    pv_valid = 1'b1;
    @(posedge clk); #1;
    pv_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_error", error, 0);
    check("midrst_busy", busy, 0);
    check("midrst_delta_t", delta_t, 0);
    @(posedge clk); #1;
    check("midrst_no_start", start_calc, 0);
    rst = 1'b0;
    model_reset();
    frame(32'h0000_0190, 32'h0000_03E8);
    check("midrst_ramp", error, 32'h0000_0384);

    // Overrun while waiting, then a pid_done timeout.
    send(32'h0000_0190, 32'h0000_03E8, 1'b0, '0);
    saved_err = error;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      pv_valid = (n == 1 || n == 3 || n == 5);
      if (n == 10) begin
        check("overrun_cnt", overrun_cnt, 3);
        check("overrun_err_hold", error, saved_err);
      end
      if (n == 1024) check("timeout_not_early", timeout, 0);
    end while (busy && n < TIMEOUT + 50);
    pv_valid = 1'b0;
    check("timeout_cycles", n, 1025);
    check("timeout_flag", timeout, 1);
    check("timeout_busy", busy, 0);

    // Deadband boundary: |diff| = 15 then 16.
    for (int i = 0; i < DEPTH; i++) frame(32'h0000_0064, 32'h0000_0073);
`ifdef ERR_DEADBAND_EN
    check("mag15", error, 32'h0000_0000);
`else
    check("mag15", error, 32'h0000_000F);
`endif
    frame(32'h0000_0064, 32'h0000_0074);
    check("mag16", error, 32'h0000_0010);
    check("timeout_sticky", timeout, 1);

    // en low freezes the frame and ignores stray samples.
    setpoint = 32'h0000_006E;
    pv       = 32'h0000_0064;
    pv_valid = 1'b1;
    exp_q.push_back(model_sample(32'h0000_0064, 32'h0000_006E));
    @(posedge clk); #1;
    pv_valid = 1'b0;
    en = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      pv_valid = ~pv_valid;
    end
    pv_valid = 1'b0;
    check("en_low_no_start", start_calc, 0);
    check("en_low_busy", busy, 1);
    check("en_low_overrun", overrun_cnt, 3);
    en = 1'b1;
    n = 0;
    while (!start_calc && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("en_resume_latency", n, 2);
    if (exp_q.size() > 0) check("en_error", error, exp_q.pop_front());
    done_after(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
